// File: rtl/tpu_pkg.sv
// Shared definitions for the tiled systolic matrix-multiply block:
// FSM state encoding, default widths and a ceiling-division helper.
package tpu_pkg;

  localparam int DEF_ARRAY_S = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_IDX_W   = 16;
  localparam int DIM_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } tpu_state_e;

  // Number of den-wide strips needed to cover num elements.
  function automatic logic [DIM_W-1:0] ceil_div(input logic [DIM_W-1:0] num,
                                                input logic [DIM_W-1:0] den);
    logic [DIM_W:0] sum;
    sum = {1'b0, num} + {1'b0, den} - (DIM_W+1)'(1);
    return DIM_W'(sum / {1'b0, den});
  endfunction

endpackage

// File: rtl/tpu_pe_mac.sv
// One processing element of the output-stationary array: forwards its A
// operand right and its B operand down through registers, and accumulates
// the signed product into a wrapping ACC_W accumulator.
module tpu_pe_mac
  import tpu_pkg::*;
#(
  parameter int A_W   = DEF_DATA_W,
  parameter int B_W   = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [A_W-1:0]   a_o,
  output logic [B_W-1:0]   b_o,
  output logic [ACC_W-1:0] acc_o
);

  localparam int P_W = A_W + B_W;

  logic [A_W-1:0]        a_q;
  logic [B_W-1:0]        b_q;
  logic [ACC_W-1:0]      acc_q;
  logic signed [P_W-1:0] prod;

  assign prod = P_W'($signed(a_i)) * P_W'($signed(b_i));

  // Operand forwarding and multiply-accumulate; clear starts a new tile.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every PE
    // samples its neighbour's value from before this edge.
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= clr_i ? '0 : acc_q + ACC_W'(prod);
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/tpu_tiled_array.sv
// S x S output-stationary systolic array computing C = A*B for arbitrary
// M x K by K x N problems by tiling M and N into S-wide strips.
// Optional feature macro: TPU_OFFSET_EN adds a signed offset to A elements.
module tpu_tiled_array
  import tpu_pkg::*;
#(
  parameter int ARRAY_S = DEF_ARRAY_S,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DIM_W-1:0]          K,
  input  logic [DIM_W-1:0]          M,
  input  logic [DIM_W-1:0]          N,
`ifdef TPU_OFFSET_EN
  input  logic [DATA_W:0]           in_offset,
`endif
  output logic                      busy,
  output logic                      A_wr_en,
  output logic                      B_wr_en,
  output logic [IDX_W-1:0]          A_index,
  output logic [IDX_W-1:0]          B_index,
  output logic [ARRAY_S*DATA_W-1:0] A_data_in,
  output logic [ARRAY_S*DATA_W-1:0] B_data_in,
  input  logic [ARRAY_S*DATA_W-1:0] A_data_out,
  input  logic [ARRAY_S*DATA_W-1:0] B_data_out,
  output logic                      C_wr_en,
  output logic [IDX_W-1:0]          C_index,
  output logic [ARRAY_S*ACC_W-1:0]  C_data_in,
  input  logic [ARRAY_S*ACC_W-1:0]  C_data_out
);

`ifdef TPU_OFFSET_EN
  localparam int A_W = DATA_W + 1;
`else
  localparam int A_W = DATA_W;
`endif
  localparam int ROW_W = $clog2(ARRAY_S);
  localparam logic [DIM_W-1:0] DRAIN_LAST = DIM_W'(2 * ARRAY_S - 1);
  localparam logic [DIM_W-1:0] WRITE_LAST = DIM_W'(ARRAY_S - 1);

  tpu_state_e state_q, state_d;
  logic [DIM_W-1:0] cnt_q, cnt_d;
  logic [DIM_W-1:0] k_q, m_q, n_q, mt_q, nt_q;
  logic [DIM_W-1:0] m_tile_q, m_tile_d, n_tile_q, n_tile_d;
  logic [IDX_W-1:0] m_base_q, m_base_d, n_base_q, n_base_d;
  logic [IDX_W-1:0] a_idx_q, a_idx_d, b_idx_q, b_idx_d, c_base_q, c_base_d;
  logic             feed_vld_q;
  logic             c_wr_en_q;
  logic [IDX_W-1:0] c_idx_q;
  logic [ARRAY_S*ACC_W-1:0] c_data_q, c_row;
  logic [ARRAY_S*ACC_W-1:0] c_rd_unused;
`ifdef TPU_OFFSET_EN
  logic [A_W-1:0]   offset_q;
`endif

  logic start, last_m, last_n, tile_clr, row_live;
  logic [ROW_W-1:0] row_sel;

  assign start    = (state_q == IDLE) && in_valid;
  assign last_m   = (m_tile_q == mt_q - DIM_W'(1));
  assign last_n   = (n_tile_q == nt_q - DIM_W'(1));
  assign tile_clr = (state_q == FEED) && (cnt_q == '0);
  assign row_sel  = cnt_q[ROW_W-1:0];
  assign row_live = (m_base_q + IDX_W'(cnt_q)) < IDX_W'(m_q);

  // Problem dimensions and tile counts captured at the accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= '0;
      m_q  <= '0;
      n_q  <= '0;
      mt_q <= '0;
      nt_q <= '0;
`ifdef TPU_OFFSET_EN
      offset_q <= '0;
`endif
    end else if (start) begin
      k_q  <= K;
      m_q  <= M;
      n_q  <= N;
      mt_q <= ceil_div(M, DIM_W'(ARRAY_S));
      nt_q <= ceil_div(N, DIM_W'(ARRAY_S));
`ifdef TPU_OFFSET_EN
      offset_q <= in_offset;
`endif
    end
  end

  // FSM state, phase counter, tile position and buffer address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m_tile_q   <= '0;
      n_tile_q   <= '0;
      m_base_q   <= '0;
      n_base_q   <= '0;
      a_idx_q    <= '0;
      b_idx_q    <= '0;
      c_base_q   <= '0;
      feed_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_tile_q   <= m_tile_d;
      n_tile_q   <= n_tile_d;
      m_base_q   <= m_base_d;
      n_base_q   <= n_base_d;
      a_idx_q    <= a_idx_d;
      b_idx_q    <= b_idx_d;
      c_base_q   <= c_base_d;
      feed_vld_q <= (state_q == FEED);
    end
  end

  // Next-state logic: phase sequencing, index stepping and tile advance.
  always_comb begin
    // NOTE: every signal gets a hold default up front so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + DIM_W'(1);
    m_tile_d = m_tile_q;
    n_tile_d = n_tile_q;
    m_base_d = m_base_q;
    n_base_d = n_base_q;
    a_idx_d  = a_idx_q;
    b_idx_d  = b_idx_q;
    c_base_d = c_base_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (K == '0 || M == '0 || N == '0) begin
            state_d = DONE;
          end else begin
            state_d  = FEED;
            m_tile_d = '0;
            n_tile_d = '0;
            m_base_d = '0;
            n_base_d = '0;
            a_idx_d  = '0;
            b_idx_d  = '0;
            c_base_d = '0;
          end
        end
      end
      FEED: begin
        if (cnt_q == k_q - DIM_W'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          a_idx_d = a_idx_q + IDX_W'(1);
          b_idx_d = b_idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (cnt_q == WRITE_LAST) begin
          cnt_d = '0;
          if (last_m && last_n) begin
            state_d = DONE;
          end else begin
            state_d  = FEED;
            c_base_d = c_base_q + IDX_W'(ARRAY_S);
            if (last_m) begin
              // Next column strip: A restarts, B moves to the next strip.
              m_tile_d = '0;
              m_base_d = '0;
              n_tile_d = n_tile_q + DIM_W'(1);
              n_base_d = n_base_q + IDX_W'(ARRAY_S);
              a_idx_d  = '0;
              b_idx_d  = b_idx_q + IDX_W'(1);
            end else begin
              // Next row strip: A moves on, B rewinds to its strip start.
              m_tile_d = m_tile_q + DIM_W'(1);
              m_base_d = m_base_q + IDX_W'(ARRAY_S);
              a_idx_d  = a_idx_q + IDX_W'(1);
              b_idx_d  = b_idx_q - IDX_W'(k_q) + IDX_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [A_W-1:0]    a_bus [ARRAY_S][ARRAY_S+1];
  logic [DATA_W-1:0] b_bus [ARRAY_S+1][ARRAY_S];
  logic [ACC_W-1:0]  acc   [ARRAY_S][ARRAY_S];
  logic [A_W-1:0]    a_unused [ARRAY_S];
  logic [DATA_W-1:0] b_unused [ARRAY_S];

  for (genvar i = 0; i < ARRAY_S; i++) begin : g_lane
    logic [DATA_W-1:0] a_raw, b_raw, b_msk;
    logic [A_W-1:0]    a_val, a_msk;

    assign a_raw = A_data_out[(ARRAY_S-1-i)*DATA_W +: DATA_W];
    assign b_raw = B_data_out[(ARRAY_S-1-i)*DATA_W +: DATA_W];
`ifdef TPU_OFFSET_EN
    assign a_val = {a_raw[DATA_W-1], a_raw} + offset_q;
`else
    assign a_val = a_raw;
`endif
    // Lanes past the matrix edge carry zeros into the array.
    assign a_msk = (feed_vld_q && (m_base_q + IDX_W'(i) < IDX_W'(m_q))) ? a_val : '0;
    assign b_msk = (feed_vld_q && (n_base_q + IDX_W'(i) < IDX_W'(n_q))) ? b_raw : '0;

    if (i == 0) begin : g_direct
      assign a_bus[i][0] = a_msk;
      assign b_bus[0][i] = b_msk;
    end else begin : g_skew
      logic [A_W-1:0]    a_sh_q [i];
      logic [DATA_W-1:0] b_sh_q [i];

      // Per-lane delay line of depth i aligning the operand wavefront.
      always_ff @(posedge clk) begin
        // NOTE: these short delay lines are reset explicitly so an aborted
        // run cannot leak stale operands into the next tile.
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_sh_q[d] <= '0;
            b_sh_q[d] <= '0;
          end
        end else begin
          a_sh_q[0] <= a_msk;
          b_sh_q[0] <= b_msk;
          for (int d = 1; d < i; d++) begin
            a_sh_q[d] <= a_sh_q[d-1];
            b_sh_q[d] <= b_sh_q[d-1];
          end
        end
      end

      assign a_bus[i][0] = a_sh_q[i-1];
      assign b_bus[0][i] = b_sh_q[i-1];
    end

    assign a_unused[i] = a_bus[i][ARRAY_S];
    assign b_unused[i] = b_bus[ARRAY_S][i];
  end

  for (genvar i = 0; i < ARRAY_S; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_S; j++) begin : g_col
      tpu_pe_mac #(
        .A_W  (A_W),
        .B_W  (DATA_W),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .en_i (busy),
        .clr_i(tile_clr),
        .a_i  (a_bus[i][j]),
        .b_i  (b_bus[i][j]),
        .a_o  (a_bus[i][j+1]),
        .b_o  (b_bus[i+1][j]),
        .acc_o(acc[i][j])
      );
    end
  end

  // Select one accumulator row for write-back, column 0 in the MSBs.
  always_comb begin
    c_row = '0;
    for (int j = 0; j < ARRAY_S; j++) begin
      c_row[(ARRAY_S-1-j)*ACC_W +: ACC_W] = acc[row_sel][j];
    end
  end

  // Registered C write port; rows beyond M are never strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_wr_en_q <= 1'b0;
      c_idx_q   <= '0;
      c_data_q  <= '0;
    end else if (state_q == WRITE) begin
      c_wr_en_q <= row_live;
      c_idx_q   <= c_base_q + IDX_W'(cnt_q);
      c_data_q  <= c_row;
    end else begin
      c_wr_en_q <= 1'b0;
    end
  end

  assign c_rd_unused = C_data_out;
  assign busy        = (state_q != IDLE);
  assign A_wr_en     = 1'b0;
  assign B_wr_en     = 1'b0;
  assign A_data_in   = '0;
  assign B_data_in   = '0;
  assign A_index     = a_idx_q;
  assign B_index     = b_idx_q;
  assign C_wr_en     = c_wr_en_q;
  assign C_index     = c_idx_q;
  assign C_data_in   = c_data_q;

endmodule

// File: tb/tb_tpu_tiled_array.sv
// Directed bench for tpu_tiled_array (S=4, 8-bit operands, 32-bit results).
// Buffers A and B are modelled as one-cycle-latency ROMs; C writes are
// captured into a scoreboard with a per-index strobe count.
module tb_tpu_tiled_array;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int CW = S * AW;

  localparam int A_ID = 0, A_ONE = 1, A_N128 = 2;
  localparam int B_RAMP = 0, B_NEG = 1, B_ONE = 2, B_FIVE = 3, B_WP1 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    K, M, N;
`ifdef TPU_OFFSET_EN
  logic [DW:0]   in_offset;
`endif
  logic          busy, A_wr_en, B_wr_en, C_wr_en;
  logic [IW-1:0] A_index, B_index, C_index;
  logic [S*DW-1:0] A_data_in, B_data_in, A_data_out, B_data_out;
  logic [CW-1:0] C_data_in, C_data_out;

  logic [S*DW-1:0] a_mem [64];
  logic [S*DW-1:0] b_mem [64];
  logic [CW-1:0]   c_mem [64];
  int              c_hits [64];
  int              n_wr = 0;
  int              n_checks = 0;
  int              n_fail = 0;

  typedef struct {
    logic [7:0]  k, m, n;
    int          ak, bk;
    int          exp_busy;
    int          exp_rows;
    logic [31:0] base;
    int          rstep, cstep, ncols;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  tpu_tiled_array #(.ARRAY_S(S), .DATA_W(DW), .ACC_W(AW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .K         (K),
    .M         (M),
    .N         (N),
`ifdef TPU_OFFSET_EN
    .in_offset (in_offset),
`endif
    .busy      (busy),
    .A_wr_en   (A_wr_en),
    .B_wr_en   (B_wr_en),
    .A_index   (A_index),
    .B_index   (B_index),
    .A_data_in (A_data_in),
    .B_data_in (B_data_in),
    .A_data_out(A_data_out),
    .B_data_out(B_data_out),
    .C_wr_en   (C_wr_en),
    .C_index   (C_index),
    .C_data_in (C_data_in),
    .C_data_out(C_data_out)
  );

  assign C_data_out = '0;

  always @(posedge clk) begin
    A_data_out <= a_mem[A_index[5:0]];
    B_data_out <= b_mem[B_index[5:0]];
  end

  always @(negedge clk) begin
    if (C_wr_en) begin
      c_mem[C_index[5:0]]  = C_data_in;
      c_hits[C_index[5:0]] = c_hits[C_index[5:0]] + 1;
      n_wr = n_wr + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill(input int ak, input int bk);
    for (int w = 0; w < 64; w++) begin
      for (int l = 0; l < S; l++) begin
        logic [7:0] av, bv;
        case (ak)
          A_ID:    av = (l == w) ? 8'd1 : 8'd0;
          A_ONE:   av = 8'd1;
          default: av = 8'h80;
        endcase
        case (bk)
          B_RAMP:  bv = 8'(4 * w + l);
          B_NEG:   bv = 8'hFF;
          B_ONE:   bv = 8'd1;
          B_FIVE:  bv = 8'd5;
          default: bv = 8'(w + 1);
        endcase
        a_mem[w][(S-1-l)*DW +: DW] = av;
        b_mem[w][(S-1-l)*DW +: DW] = bv;
      end
    end
  endtask

  function automatic logic [CW-1:0] build_row(input logic [31:0] base, input int rstep,
                                              input int cstep, input int ncols, input int r);
    logic [CW-1:0] row;
    row = '0;
    for (int j = 0; j < S; j++)
      row[(S-1-j)*AW +: AW] = (j < ncols) ? base + 32'(r * rstep + j * cstep) : 32'd0;
    return row;
  endfunction

  // Start a job from an idle negedge and count busy-high cycles.
  task automatic run_job(input logic [7:0] k, m, n, input int off, output int cycles);
    for (int i = 0; i < 64; i++) c_hits[i] = 0;
    K = k; M = m; N = n;
`ifdef TPU_OFFSET_EN
    in_offset = off[DW:0];
`else
    if (off != 0) $display("offset %0d ignored in this build", off);
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 2000) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 2000) check("busy timeout", 1, 0);
  endtask

  task automatic check_rows(input string tag, input int first_idx, input int nrows,
                            input logic [31:0] base, input int rstep, input int cstep,
                            input int ncols);
    for (int r = 0; r < nrows; r++) begin
      check($sformatf("%s strobes idx %0d", tag, first_idx + r), c_hits[first_idx + r], 1);
      check($sformatf("%s row idx %0d", tag, first_idx + r), c_mem[first_idx + r],
            build_row(base, rstep, cstep, ncols, r));
    end
  endtask

  task automatic apply_vec(input int v);
    int cyc;
    fill(vecs[v].ak, vecs[v].bk);
    run_job(vecs[v].k, vecs[v].m, vecs[v].n, 0, cyc);
    check($sformatf("vec%0d busy cycles", v), cyc, vecs[v].exp_busy);
    check_rows($sformatf("vec%0d", v), 0, vecs[v].exp_rows, vecs[v].base,
               vecs[v].rstep, vecs[v].cstep, vecs[v].ncols);
    for (int i = vecs[v].exp_rows; i < 8; i++)
      check($sformatf("vec%0d no strobe idx %0d", v, i), c_hits[i], 0);
  endtask

  initial begin
    int cyc, wr_snap, guard;
    logic [IW-1:0] ai_snap, bi_snap;

    vecs[0] = '{k: 8'd4, m: 8'd4, n: 8'd4, ak: A_ID,  bk: B_RAMP, exp_busy: 17, exp_rows: 4,
                base: 32'd0, rstep: 4, cstep: 1, ncols: 4};
    vecs[1] = '{k: 8'd1, m: 8'd4, n: 8'd4, ak: A_ONE, bk: B_NEG,  exp_busy: 14, exp_rows: 4,
                base: 32'hFFFF_FFFF, rstep: 0, cstep: 0, ncols: 4};
    vecs[2] = '{k: 8'd2, m: 8'd5, n: 8'd3, ak: A_ONE, bk: B_ONE,  exp_busy: 29, exp_rows: 5,
                base: 32'd2, rstep: 0, cstep: 0, ncols: 3};

    rst = 1'b1; in_valid = 1'b0; K = '0; M = '0; N = '0;
`ifdef TPU_OFFSET_EN
    in_offset = '0;
`endif
    for (int i = 0; i < 64; i++) begin c_hits[i] = 0; c_mem[i] = '0; end
    fill(A_ONE, B_ONE);
    repeat (3) @(negedge clk);

    check("reset busy", busy, 0);
    check("reset C_wr_en", C_wr_en, 0);
    check("reset A_wr_en/B_wr_en", {A_wr_en, B_wr_en}, 0);
    check("reset A_index", A_index, 0);
    check("reset B_index", B_index, 0);
    check("reset C_index", C_index, 0);
    check("reset C_data_in", C_data_in, 0);
    check("reset A/B data_in", {A_data_in, B_data_in}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) apply_vec(v);

    // Two column strips (NT=2, MT=1): B strip advance and A rewind.
    fill(A_ONE, B_WP1);
    run_job(8'd3, 8'd2, 8'd6, 0, cyc);
    check("nt2 busy cycles", cyc, 31);
    check_rows("nt2 strip0", 0, 2, 32'd6, 0, 0, 4);
    check_rows("nt2 strip1", 4, 2, 32'd15, 0, 0, 2);
    check("nt2 no strobe idx 2", c_hits[2], 0);
    check("nt2 no strobe idx 3", c_hits[3], 0);
    check("nt2 no strobe idx 6", c_hits[6], 0);
    check("nt2 no strobe idx 7", c_hits[7], 0);

    // Zero dimension: one busy cycle, no index movement, no writes.
    ai_snap = A_index; bi_snap = B_index; wr_snap = n_wr;
    run_job(8'd0, 8'd4, 8'd4, 0, cyc);
    check("zero-dim busy cycles", cyc, 1);
    check("zero-dim writes", n_wr - wr_snap, 0);
    check("zero-dim A_index held", A_index, ai_snap);
    check("zero-dim B_index held", B_index, bi_snap);
    apply_vec(1);

    // Reset during the first write phase of an M=8 job.
    fill(A_ONE, B_ONE);
    K = 8'd4; M = 8'd8; N = 8'd4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!C_wr_en && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("reset-test reached WRITE", guard < 200, 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset-test busy after rst", busy, 0);
    check("reset-test C_wr_en after rst", C_wr_en, 0);
    rst = 1'b0;
    wr_snap = n_wr;
    repeat (40) @(negedge clk);
    check("reset-test no later writes", n_wr - wr_snap, 0);
    check("reset-test stays idle", busy, 0);
    apply_vec(0);

`ifdef TPU_OFFSET_EN
    fill(A_N128, B_FIVE);
    run_job(8'd4, 8'd4, 8'd4, 128, cyc);
    check("offset128 busy cycles", cyc, 17);
    check_rows("offset128", 0, 4, 32'd0, 0, 0, 4);
    run_job(8'd4, 8'd4, 8'd4, 129, cyc);
    check("offset129 busy cycles", cyc, 17);
    check_rows("offset129", 0, 4, 32'd20, 0, 0, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
